// File: rtl/hamm_scrub_ctrl.sv
// Background SECDED(12,8)+parity memory scrubber: reads every word,
// writes back single-bit corrections, counts and logs double errors.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, clr_stats  begin a pass / clear statistics
//   busy, done        pass in progress / last word finished
//   mem_req, mem_we   memory request / write enable
//   mem_addr          word address
//   mem_wdata         corrected word {parity, code[11:0]}
//   mem_rdata         read word
//   mem_ack           one-cycle completion strobe
//   sec_count         corrected-error count (saturating)
//   ded_count         uncorrectable-error count (saturating)
//   ded_flag          sticky uncorrectable-error flag
//   ded_addr          address of first uncorrectable error
module hamm_scrub_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int INTERVAL = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clr_stats,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [12:0]       mem_wdata,
  input  logic [12:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       sec_count,
  output logic [15:0]       ded_count,
  output logic              ded_flag,
  output logic [ADDR_W-1:0] ded_addr
);

  typedef enum logic [2:0] {
    IDLE, WAIT, READ, CHECK, WRITE, NEXT
  } state_t;

  localparam int CW =
    (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CW-1:0] WLAST =
    CW'(INTERVAL - 1);
  localparam logic [ADDR_W-1:0] ALAST =
    ADDR_W'(DEPTH - 1);

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr;
  logic [CW-1:0]     wcnt;
  logic [12:0]       rword;
  logic              last;

  logic [11:0] code;
  logic [11:0] flip;
  logic [11:0] cfix;
  logic [3:0]  syn;
  logic        pm;
  logic        sec_hit;
  logic        ded_hit;

  logic [15:0]       sec_nx;
  logic [15:0]       ded_nx;
  logic              flag_nx;
  logic [ADDR_W-1:0] daddr_nx;

  assign last = (addr == ALAST);

  // Decode of the captured word
  assign code = rword[11:0];
  assign syn  = {^(code & 12'hF80),
                 ^(code & 12'h878),
                 ^(code & 12'h666),
                 ^(code & 12'h555)};
  assign pm   = rword[12] ^ (^code);

  // s = 0 with pm is a parity-bit error:
  // flip stays zero and only parity is
  // recomputed.
  assign sec_hit = pm && (syn <= 4'd12);
  assign ded_hit = (syn != 4'd0 && !pm)
                || (pm && syn > 4'd12);

  assign flip =
    (syn != 4'd0 && syn <= 4'd12)
      ? (12'd1 << (syn - 4'd1))
      : 12'd0;
  assign cfix = code ^ flip;

  assign busy     = (state != IDLE);
  assign done     = (state == NEXT) && last;
  assign mem_req  = (state == READ)
                 || (state == WRITE);
  assign mem_we   = (state == WRITE);
  assign mem_addr = addr;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = WAIT;
      WAIT:  if (wcnt == WLAST)
               state_nx = READ;
      READ:  if (mem_ack) state_nx = CHECK;
      CHECK: state_nx = sec_hit ? WRITE
                                : NEXT;
      WRITE: if (mem_ack) state_nx = NEXT;
      NEXT:  state_nx = last ? IDLE : WAIT;
      default: state_nx = IDLE;
    endcase
  end

  // Clear is applied before a same-cycle
  // increment, so a colliding event still
  // counts once.
  always_comb begin
    sec_nx   = clr_stats ? 16'd0 : sec_count;
    ded_nx   = clr_stats ? 16'd0 : ded_count;
    flag_nx  = clr_stats ? 1'b0 : ded_flag;
    daddr_nx = clr_stats ? '0 : ded_addr;
    if (state == CHECK) begin
      if (sec_hit && sec_nx != 16'hFFFF)
        sec_nx = sec_nx + 16'd1;
      if (ded_hit) begin
        if (ded_nx != 16'hFFFF)
          ded_nx = ded_nx + 16'd1;
        if (!flag_nx) daddr_nx = addr;
        flag_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      wcnt      <= '0;
      rword     <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start)
        addr <= '0;
      else if (state == NEXT && !last)
        addr <= addr + 1'b1;
      if (state == WAIT)
        wcnt <= wcnt + 1'b1;
      else
        wcnt <= '0;
      if (state == READ && mem_ack)
        rword <= mem_rdata;
      if (state == CHECK)
        mem_wdata <= {^cfix, cfix};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_count <= '0;
      ded_count <= '0;
      ded_flag  <= 1'b0;
      ded_addr  <= '0;
    end else begin
      sec_count <= sec_nx;
      ded_count <= ded_nx;
      ded_flag  <= flag_nx;
      ded_addr  <= daddr_nx;
    end
  end

endmodule
